// File: rtl/dat_xfer_sched_pkg.sv
// Shared definitions for the DAT transfer sequencer and its timeout counter.
package dat_xfer_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BUF = 3'd1,
        S_XFER     = 3'd2,
        S_GAP      = 3'd3,
        S_DONE     = 3'd4,
        S_ERR      = 3'd5
    } xfer_state_e;

    // Transfer Mode Register bit positions
    localparam int TMR_READ_BIT  = 4;
    localparam int TMR_MULTI_BIT = 5;
    localparam int TMR_BC_EN_BIT = 1;

    // Block Gap Control Register bit positions
    localparam int BGCR_STOP_BIT = 0;
    localparam int BGCR_CONT_BIT = 1;

    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Read waits on the RX FIFO, write waits on the TX FIFO.
    function automatic logic buf_ready(input logic dir_read,
                                       input logic tx_empty,
                                       input logic rx_full);
        return dir_read ? !rx_full : !tx_empty;
    endfunction

endpackage

// File: rtl/dat_xfer_sched_timeout.sv
// Saturating up-counter with clear/enable. tc_o flags the cycle on which the
// count steps onto LIMIT-1, so the owner can leave on that same edge.
module dat_timeout_cnt
    import dat_xfer_sched_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int W = $clog2(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] PRE  = W'(LIMIT - 2);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q;

    // Count while enabled, hold at the terminal value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign tc_o = en_i && !clr_i && (cnt_q >= PRE);

endmodule

// File: rtl/dat_xfer_sched.sv
// Block-level transfer sequencer between the ADMA/FIFO side and the DAT engine.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no transfer; waits for start_transfer
//   WAIT_BUF | waits until the FIFO can source/sink a block, then launches
//   XFER     | block in flight on DAT; timeout running
//   GAP      | stopped at a block gap; waits for continue_req
//   DONE     | one cycle, transfer_complete asserted
//   ERR      | config/CRC/timeout error; held until abort
module dat_xfer_sched
    import dat_xfer_sched_pkg::*;
#(
    parameter int BLK_CNT_W      = 16,
    parameter int BLK_SIZE_W     = 12,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_transfer_i,
    input  logic                  abort_i,
    input  logic                  tm_read_i,
    input  logic                  tm_multi_i,
    input  logic                  tm_bc_en_i,
    input  logic [BLK_SIZE_W-1:0] block_size_i,
    input  logic [BLK_CNT_W-1:0]  block_count_i,
    input  logic                  stop_at_gap_i,
    input  logic                  continue_req_i,
    input  logic                  tx_buf_empty_i,
    input  logic                  rx_buf_full_i,
    input  logic                  dat_block_done_i,
    input  logic                  dat_crc_err_i,
    output logic                  dat_start_o,
    output logic                  dat_dir_o,
    output logic [BLK_SIZE_W-1:0] dat_block_size_o,
    output logic [BLK_CNT_W-1:0]  blocks_left_o,
    output logic                  xfer_active_o,
    output logic                  transfer_complete_o,
    output logic                  block_gap_event_o,
    output logic                  data_timeout_err_o,
    output logic                  data_crc_err_o,
    output logic                  cfg_err_o
);

    localparam logic [BLK_CNT_W-1:0] ONE_BLK = BLK_CNT_W'(1);

    xfer_state_e state_q, state_d;

    logic                  multi_q, multi_d;
    logic                  bc_en_q, bc_en_d;
    logic                  dir_q, dir_d;
    logic [BLK_SIZE_W-1:0] size_q, size_d;
    logic [BLK_CNT_W-1:0]  blocks_q, blocks_d;
    logic dat_start_q, dat_start_d;
    logic active_q, active_d;
    logic cmp_q, cmp_d;
    logic gap_q, gap_d;
    logic tmo_q, tmo_d;
    logic crc_q, crc_d;
    logic cfg_q, cfg_d;

    logic buf_ok, infinite, last_blk, tmo_tc;

    assign buf_ok   = buf_ready(dir_q, tx_buf_empty_i, rx_buf_full_i);
    assign infinite = multi_q && !bc_en_q;
    assign last_blk = !multi_q || (bc_en_q && (blocks_q == ONE_BLK));

    dat_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  ((state_q == S_WAIT_BUF) && buf_ok),
        .en_i   (state_q == S_XFER),
        .tc_o   (tmo_tc)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_transfer_i) begin
                    if (block_size_i == '0)
                        state_d = S_ERR;
                    else if (tm_multi_i && tm_bc_en_i && (block_count_i == '0))
                        state_d = S_DONE;
                    else
                        state_d = S_WAIT_BUF;
                end
            end
            S_WAIT_BUF: if (buf_ok) state_d = S_XFER;
            S_XFER: begin
                if (dat_block_done_i) begin
                    if (dat_crc_err_i)      state_d = S_ERR;
                    else if (last_blk)      state_d = S_DONE;
                    else if (stop_at_gap_i) state_d = S_GAP;
                    else                    state_d = S_WAIT_BUF;
                end else if (tmo_tc) begin
                    state_d = S_ERR;
                end
            end
            S_GAP:   if (continue_req_i) state_d = S_WAIT_BUF;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
        if (abort_i) state_d = S_IDLE;
    end

    // Output/datapath next values derived from the chosen transition.
    always_comb begin
        multi_d  = multi_q;
        bc_en_d  = bc_en_q;
        dir_d    = dir_q;
        size_d   = size_q;
        blocks_d = blocks_q;

        dat_start_d = (state_q == S_WAIT_BUF) && (state_d == S_XFER);
        cmp_d       = (state_d == S_DONE);
        gap_d       = (state_q == S_XFER) && (state_d == S_GAP);
        tmo_d       = (state_q == S_XFER) && (state_d == S_ERR) && !dat_block_done_i;
        crc_d       = (state_q == S_XFER) && (state_d == S_ERR) && dat_block_done_i;
        cfg_d       = (state_q == S_IDLE) && (state_d == S_ERR);
        active_d    = (state_d != S_IDLE);

        if ((state_q == S_IDLE) && start_transfer_i && !abort_i) begin
            multi_d = tm_multi_i;
            bc_en_d = tm_bc_en_i;
            dir_d   = tm_read_i;
            size_d  = block_size_i;
            if (!tm_multi_i)     blocks_d = ONE_BLK;
            else if (tm_bc_en_i) blocks_d = block_count_i;
        end

        if ((state_q == S_XFER) && dat_block_done_i && !dat_crc_err_i && !abort_i
            && !infinite && (blocks_q != '0))
            blocks_d = blocks_q - ONE_BLK;
    end

    // Registered outputs and latched configuration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            multi_q     <= 1'b0;
            bc_en_q     <= 1'b0;
            dir_q       <= 1'b0;
            size_q      <= '0;
            blocks_q    <= '0;
            dat_start_q <= 1'b0;
            active_q    <= 1'b0;
            cmp_q       <= 1'b0;
            gap_q       <= 1'b0;
            tmo_q       <= 1'b0;
            crc_q       <= 1'b0;
            cfg_q       <= 1'b0;
        end else begin
            multi_q     <= multi_d;
            bc_en_q     <= bc_en_d;
            dir_q       <= dir_d;
            size_q      <= size_d;
            blocks_q    <= blocks_d;
            dat_start_q <= dat_start_d;
            active_q    <= active_d;
            cmp_q       <= cmp_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            crc_q       <= crc_d;
            cfg_q       <= cfg_d;
        end
    end

    assign dat_start_o         = dat_start_q;
    assign dat_dir_o           = dir_q;
    assign dat_block_size_o    = size_q;
    assign blocks_left_o       = blocks_q;
    assign xfer_active_o       = active_q;
    assign transfer_complete_o = cmp_q;
    assign block_gap_event_o   = gap_q;
    assign data_timeout_err_o  = tmo_q;
    assign data_crc_err_o      = crc_q;
    assign cfg_err_o           = cfg_q;

endmodule

// File: tb/tb_dat_xfer_sched.sv
// Bench for dat_xfer_sched: transaction-level model plus directed scenarios.
module tb_dat_xfer_sched;

    localparam int CW  = 16;
    localparam int SW  = 12;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_transfer = 0, abort = 0, tm_read = 0, tm_multi = 0, tm_bc_en = 0;
    logic [SW-1:0] block_size = '0;
    logic [CW-1:0] block_count = '0;
    logic stop_at_gap = 0, continue_req = 0, tx_buf_empty = 1, rx_buf_full = 1;
    logic dat_block_done = 0, dat_crc_err = 0;

    logic dat_start, dat_dir, xfer_active, transfer_complete, block_gap_event;
    logic data_timeout_err, data_crc_err, cfg_err;
    logic [SW-1:0] dat_block_size;
    logic [CW-1:0] blocks_left;

    always #5 clk = ~clk;

    dat_xfer_sched #(.BLK_CNT_W(CW), .BLK_SIZE_W(SW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .start_transfer_i(start_transfer), .abort_i(abort),
        .tm_read_i(tm_read), .tm_multi_i(tm_multi), .tm_bc_en_i(tm_bc_en),
        .block_size_i(block_size), .block_count_i(block_count),
        .stop_at_gap_i(stop_at_gap), .continue_req_i(continue_req),
        .tx_buf_empty_i(tx_buf_empty), .rx_buf_full_i(rx_buf_full),
        .dat_block_done_i(dat_block_done), .dat_crc_err_i(dat_crc_err),
        .dat_start_o(dat_start), .dat_dir_o(dat_dir),
        .dat_block_size_o(dat_block_size), .blocks_left_o(blocks_left),
        .xfer_active_o(xfer_active), .transfer_complete_o(transfer_complete),
        .block_gap_event_o(block_gap_event), .data_timeout_err_o(data_timeout_err),
        .data_crc_err_o(data_crc_err), .cfg_err_o(cfg_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    // Kinds: 0 single, 1 counted, 2 infinite.
    int m_active = 0, m_dir = 0, m_size = 0, m_left = 0, m_kind = 0, m_age = 0;
    int m_waiting = 0, m_flying = 0, m_paused = 0, m_finishing = 0, m_failed = 0;
    int e_start = 0, e_cmp = 0, e_gap = 0, e_tmo = 0, e_crc = 0, e_cfg = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 0; m_dir = 0; m_size = 0; m_left = 0; m_kind = 0; m_age = 0;
            m_waiting = 0; m_flying = 0; m_paused = 0; m_finishing = 0; m_failed = 0;
            e_start = 0; e_cmp = 0; e_gap = 0; e_tmo = 0; e_crc = 0; e_cfg = 0;
        end else begin
            e_start = 0; e_cmp = 0; e_gap = 0; e_tmo = 0; e_crc = 0; e_cfg = 0;
            if (abort) begin
                m_active = 0; m_waiting = 0; m_flying = 0; m_paused = 0;
                m_finishing = 0; m_failed = 0;
            end else if (m_active == 0) begin
                if (start_transfer) begin
                    m_dir  = int'(tm_read);
                    m_size = int'(block_size);
                    m_kind = !tm_multi ? 0 : (tm_bc_en ? 1 : 2);
                    if (m_kind == 0) m_left = 1;
                    else if (m_kind == 1) m_left = int'(block_count);
                    m_active = 1;
                    if (block_size == 0) begin
                        e_cfg = 1; m_failed = 1;
                    end else if (m_kind == 1 && block_count == 0) begin
                        e_cmp = 1; m_finishing = 1;
                    end else begin
                        m_waiting = 1;
                    end
                end
            end else if (m_finishing != 0) begin
                m_active = 0; m_finishing = 0;
            end else if (m_failed != 0) begin
                m_failed = 1;
            end else if (m_paused != 0) begin
                if (continue_req) begin m_paused = 0; m_waiting = 1; end
            end else if (m_waiting != 0) begin
                if ((m_dir != 0) ? !rx_buf_full : !tx_buf_empty) begin
                    e_start = 1; m_waiting = 0; m_flying = 1; m_age = 0;
                end
            end else if (m_flying != 0) begin
                if (dat_block_done) begin
                    m_flying = 0;
                    if (dat_crc_err) begin
                        e_crc = 1; m_failed = 1;
                    end else begin
                        if (m_kind != 2 && m_left > 0) m_left--;
                        if (m_kind == 0 || (m_kind == 1 && m_left == 0)) begin
                            e_cmp = 1; m_finishing = 1;
                        end else if (stop_at_gap) begin
                            e_gap = 1; m_paused = 1;
                        end else begin
                            m_waiting = 1;
                        end
                    end
                end else begin
                    m_age++;
                    if (m_age == TMO - 1) begin
                        e_tmo = 1; m_flying = 0; m_failed = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    int cyc = 0;
    int ev_cnt[6];      // 0 start, 1 complete, 2 gap, 3 timeout, 4 crc, 5 cfg
    int base[6];
    int start_cyc = 0, cmp_cyc = 0, tmo_cyc = 0;

    initial begin
        for (int i = 0; i < 6; i++) ev_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cyc++;
                if (dat_start)         begin ev_cnt[0]++; start_cyc = cyc; end
                if (transfer_complete) begin ev_cnt[1]++; cmp_cyc = cyc; end
                if (block_gap_event)   ev_cnt[2]++;
                if (data_timeout_err)  begin ev_cnt[3]++; tmo_cyc = cyc; end
                if (data_crc_err)      ev_cnt[4]++;
                if (cfg_err)           ev_cnt[5]++;
                chk("dat_start",         int'(dat_start),         e_start);
                chk("transfer_complete", int'(transfer_complete), e_cmp);
                chk("block_gap_event",   int'(block_gap_event),   e_gap);
                chk("data_timeout_err",  int'(data_timeout_err),  e_tmo);
                chk("data_crc_err",      int'(data_crc_err),      e_crc);
                chk("cfg_err",           int'(cfg_err),           e_cfg);
                chk("xfer_active",       int'(xfer_active),       m_active);
                chk("dat_dir",           int'(dat_dir),           m_dir);
                chk("dat_block_size",    int'(dat_block_size),    m_size);
                chk("blocks_left",       int'(blocks_left),       m_left);
            end
        end
    end

    // ---------------- DAT engine responder ----------------
    int resp_en = 0, resp_dly = 3, resp_crc = 0;

    initial forever begin
        step();
        if (resp_en != 0 && dat_start) begin
            repeat (resp_dly - 1) step();
            dat_block_done = 1;
            dat_crc_err = (resp_crc != 0);
            step();
            dat_block_done = 0;
            dat_crc_err = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic snap();
        for (int i = 0; i < 6; i++) base[i] = ev_cnt[i];
    endtask

    function automatic int delta(input int k);
        return ev_cnt[k] - base[k];
    endfunction

    task automatic kick(input bit rd, input bit multi, input bit bcen,
                        input int size, input int cnt);
        tm_read = rd; tm_multi = multi; tm_bc_en = bcen;
        block_size = SW'(size); block_count = CW'(cnt);
        start_transfer = 1;
        step();
        start_transfer = 0;
    endtask

    task automatic wait_ev(input int k, input int tgt, input string nm);
        for (int i = 0; i < 400; i++) begin
            if (delta(k) >= tgt) break;
            step();
        end
        chk(nm, delta(k), tgt);
    endtask

    task automatic do_abort();
        abort = 1;
        step();
        abort = 0;
    endtask

    int seen_left[$];
    int exp_seq[4] = '{3, 2, 1, 0};
    int last_left;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_active", int'(xfer_active), 0);
        chk("rst_blocks_left", int'(blocks_left), 0);
        chk("rst_dat_start", int'(dat_start), 0);
        rst_n = 1;
        step();

        // Single-block write, 512 bytes
        resp_en = 1; resp_dly = 3; resp_crc = 0; tx_buf_empty = 0;
        snap();
        kick(0, 0, 0, 512, 7);
        chk("single_active", int'(xfer_active), 1);
        chk("single_no_start_yet", int'(dat_start), 0);
        step();
        chk("single_start", int'(dat_start), 1);
        wait_ev(1, 1, "single_complete");
        chk("single_cmp_latency", cmp_cyc - start_cyc, 3);
        chk("single_starts", delta(0), 1);
        chk("single_left", int'(blocks_left), 0);
        chk("single_size", int'(dat_block_size), 512);
        step();
        chk("single_idle", int'(xfer_active), 0);

        // Counted read, 3 blocks, RX FIFO full toggling
        snap();
        rx_buf_full = 1; tx_buf_empty = 1;
        seen_left.delete();
        last_left = int'(blocks_left);
        kick(1, 1, 1, 64, 3);
        for (int c = 0; c < 80; c++) begin
            rx_buf_full = ((c % 5) < 3);
            if (int'(blocks_left) != last_left) begin
                last_left = int'(blocks_left);
                seen_left.push_back(last_left);
            end
            step();
        end
        chk("cnt_starts", delta(0), 3);
        chk("cnt_complete", delta(1), 1);
        chk("cnt_dir", int'(dat_dir), 1);
        chk("cnt_seq_len", seen_left.size(), 4);
        for (int i = 0; i < 4 && i < seen_left.size(); i++)
            chk("cnt_seq", seen_left[i], exp_seq[i]);
        rx_buf_full = 1;

        // Block gap after block 2 of 4
        snap();
        tx_buf_empty = 0;
        kick(0, 1, 1, 128, 4);
        for (int i = 0; i < 100; i++) begin
            if (delta(0) >= 2) break;
            step();
        end
        stop_at_gap = 1;
        wait_ev(2, 1, "gap_event");
        repeat (6) step();
        chk("gap_hold_starts", delta(0), 2);
        chk("gap_hold_active", int'(xfer_active), 1);
        stop_at_gap = 0;
        continue_req = 1;
        step();
        continue_req = 0;
        wait_ev(1, 1, "gap_complete");
        chk("gap_starts", delta(0), 4);
        chk("gap_left", int'(blocks_left), 0);
        step();

        // Data timeout
        snap();
        resp_en = 0;
        kick(0, 0, 0, 32, 0);
        wait_ev(3, 1, "tmo_event");
        chk("tmo_latency", tmo_cyc - start_cyc, TMO - 1);
        repeat (3) step();
        chk("tmo_err_hold", int'(xfer_active), 1);
        do_abort();
        chk("tmo_abort_idle", int'(xfer_active), 0);

        // CRC error on block done
        snap();
        resp_en = 1; resp_crc = 1;
        kick(0, 0, 0, 32, 0);
        wait_ev(4, 1, "crc_event");
        step();
        chk("crc_err_hold", int'(xfer_active), 1);
        chk("crc_no_complete", delta(1), 0);
        do_abort();
        resp_crc = 0;

        // Counted with zero blocks
        snap();
        kick(0, 1, 1, 512, 0);
        wait_ev(1, 1, "zero_cnt_complete");
        step();
        chk("zero_cnt_starts", delta(0), 0);
        chk("zero_cnt_idle", int'(xfer_active), 0);

        // Zero block size
        snap();
        kick(1, 1, 1, 0, 5);
        wait_ev(5, 1, "cfg_event");
        chk("cfg_err_hold", int'(xfer_active), 1);
        do_abort();

        // Abort while waiting for the buffer suppresses the launch
        snap();
        tx_buf_empty = 1;
        kick(0, 0, 0, 16, 0);
        step();
        tx_buf_empty = 0;
        do_abort();
        step();
        chk("abort_wait_starts", delta(0), 0);

        // Abort coinciding with the last block's done
        snap();
        kick(0, 0, 0, 512, 0);
        for (int i = 0; i < 20; i++) begin
            if (dat_start) break;
            step();
        end
        repeat (resp_dly - 1) step();
        do_abort();
        repeat (3) step();
        chk("abort_last_complete", delta(1), 0);
        chk("abort_last_idle", int'(xfer_active), 0);
        chk("abort_last_left", int'(blocks_left), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dat_xfer_sched.md
Name: dat_xfer_sched

Overview:
- Block-level transfer sequencer between the ADMA/FIFO side and the DAT line engine.
- Latches the transfer configuration (transfer mode, block size, block count, block gap control) when the DMA asserts start_transfer.
- For each block, waits until the buffer can source or sink data, then launches the DAT engine one block at a time.
- Handles block-gap stop/continue and the data timeout, counts remaining blocks, and reports completion and error events for the interrupt status registers.

Parameters:
- BLK_CNT_W, 16, width of the block counter (matches Block Count Register).
- BLK_SIZE_W, 12, width of the block size field (BSR[11:0], bytes).
- TIMEOUT_CYCLES, 4096, CLK cycles allowed from dat_start to dat_block_done.

Ports:
- CLK  in  1  system clock.
- rst_L  in  1  asynchronous active-low reset.
- start_transfer  in  1  one-cycle start pulse from dma.
- abort  in  1  level; forces return to IDLE.
- tm_read  in  1  TMR[4]; 1 = card->host.
- tm_multi  in  1  TMR[5]; multi-block select.
- tm_bc_en  in  1  TMR[1]; block count enable.
- block_size  in  BLK_SIZE_W  bytes per block.
- block_count  in  BLK_CNT_W  number of blocks.
- stop_at_gap  in  1  BGCR[0].
- continue_req  in  1  BGCR[1], one-cycle pulse.
- tx_buf_empty  in  1  TX FIFO empty (write direction).
- rx_buf_full  in  1  RX FIFO full (read direction).
- dat_block_done  in  1  one-cycle pulse from DAT: block finished.
- dat_crc_err  in  1  qualifies dat_block_done.
- dat_start  out  1  one-cycle pulse launching a block.
- dat_dir  out  1  latched tm_read.
- dat_block_size  out  BLK_SIZE_W  latched block_size.
- blocks_left  out  BLK_CNT_W  remaining blocks.
- xfer_active  out  1  high in every state except IDLE.
- transfer_complete  out  1  one-cycle pulse.
- block_gap_event  out  1  one-cycle pulse.
- data_timeout_err  out  1  one-cycle pulse.
- data_crc_err  out  1  one-cycle pulse.
- cfg_err  out  1  one-cycle pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- All outputs are registered.
- States: IDLE, WAIT_BUF, XFER, GAP, DONE, ERR.

IDLE
- On start_transfer, latch tm_read, block_size, block_count and the mode bits.
- Transfer type and block budget:
  - Single block when tm_multi=0: blocks_left=1.
  - Counted multi-block when tm_multi=1 and tm_bc_en=1: blocks_left=block_count.
  - Infinite multi-block when tm_multi=1 and tm_bc_en=0: blocks_left is held and never decremented.
- Next state:
  - block_size==0 -> ERR with cfg_err pulse.
  - Counted with block_count==0 -> DONE; no dat_start is issued.
  - Otherwise -> WAIT_BUF.
- start_transfer is ignored outside IDLE.

WAIT_BUF
- Write direction: leave when tx_buf_empty=0.
- Read direction: leave when rx_buf_full=0.
- When the buffer condition holds: dat_start=1 for exactly one cycle, timeout counter cleared, -> XFER.

XFER
- Timeout counter increments every cycle.
- On dat_block_done with dat_crc_err=1: data_crc_err pulse, -> ERR.
- On dat_block_done with dat_crc_err=0:
  - Decrement blocks_left if counted.
  - If the block just finished was the last (counted blocks_left==1, or single block) -> DONE.
  - Else if stop_at_gap=1 -> GAP with block_gap_event pulse.
  - Else -> WAIT_BUF.
- Counter reaching TIMEOUT_CYCLES-1 without dat_block_done: data_timeout_err pulse, -> ERR.
- If dat_block_done coincides with the terminal count, dat_block_done wins.

GAP, DONE, ERR
- GAP: hold until continue_req, then -> WAIT_BUF. stop_at_gap is sampled only at block end.
- DONE: transfer_complete=1 for one cycle, -> IDLE.
- ERR: hold, xfer_active=1, until abort -> IDLE.

abort
- In any state, abort -> IDLE on the next edge.
- No completion or error pulse is generated; a pending dat_start is suppressed.
- abort has priority over every simultaneous event.
- blocks_left keeps its value for readback.

Other
- Reset mid-transfer: immediate return to reset values; no pulses.
- Width rules:
  - blocks_left never underflows; the decrement is guarded by !=0.
  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates.

Decomposition:
- Shared package or defines:
  - State encoding constants (S_IDLE..S_ERR, 3 bits).
  - TMR bit positions (READ=4, MULTI=5, BC_EN=1).
  - BGCR bit positions (STOP=0, CONT=1).
  - Default TIMEOUT_CYCLES.
- One natural sub-module: dat_timeout_cnt (clear/enable/terminal-count flag), reused later by the CMD response timeout.

Test Plan:
- Single-block write: tm_multi=0, block_size=512, tx_buf_empty=0.
  - Expect one dat_start 1 cycle after WAIT_BUF entry, dat_dir=0.
  - dat_block_done -> transfer_complete pulse next cycle; blocks_left=0.
- Counted read, block_count=3, rx_buf_full toggling.
  - Expect exactly 3 dat_start pulses, each only while rx_buf_full=0.
  - blocks_left steps 3->2->1->0, then one transfer_complete.
- Block gap: block_count=4, stop_at_gap=1 after block 2.
  - Expect block_gap_event, no dat_start until continue_req.
  - Then blocks 3-4 and transfer_complete.
- Timeout, TIMEOUT_CYCLES=16: no dat_block_done.
  - Expect data_timeout_err at cycle 15 after dat_start, state ERR, xfer_active=1.
  - abort -> IDLE, xfer_active=0.
- Errors and edge cases:
  - dat_crc_err with done -> data_crc_err pulse, ERR.
  - block_count=0 counted -> transfer_complete with no dat_start.
  - block_size=0 -> cfg_err.
- abort asserted in the same cycle as dat_block_done on the last block -> IDLE, no transfer_complete.
